uart_rx_engine: RTL and testbench

Serial receive engine for the UART: it deserialises an asynchronous 8-bit, LSB-first frame from the `rx` pin and presents the byte to the host-side register interface. Status flags are set by the engine and cleared by a host read strobe, with set taking priority over clear. It is the receive-side counterpart of the transmit path and feeds the same memory-mapped status/data registers.

---
 rtl/uart_rx_engine.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: 2-flop synchronised rx line, mid-bit sampling, LSB-first 8-bit frames.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN; otherwise perr is tied low.
module uart_rx_engine #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rxrdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxs;

    logic [CNT_W-1:0] r_baud_cnt;
    logic             w_expired;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    logic [7:0]       r_data;
    logic             r_rxrdy;
    logic             r_ferr;
    logic             r_ovf;

    logic             w_load_half;
    logic             w_load_full;
    logic             w_shift_en;
    logic             w_complete;
`ifdef UART_RX_PARITY_EN
    logic             w_par_en;
    logic             r_par_err;
    logic             r_perr;
`endif

    assign w_rxs     = r_sync2;
    assign w_expired = (r_baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_expired) begin
                    w_state_next = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_expired && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_expired) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_expired) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: per-state datapath controls
    always_comb begin
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift_en  = 1'b0;
        w_complete  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en    = 1'b0;
`endif
        case (r_state)
            S_IDLE:  w_load_half = ~w_rxs;
            S_START: w_load_full = w_expired & ~w_rxs;
            S_DATA: begin
                w_shift_en  = w_expired;
                w_load_full = w_expired;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_par_en    = w_expired;
                w_load_full = w_expired;
            end
`endif
            S_STOP:  w_complete = w_expired;
            default: w_load_half = 1'b0;
        endcase
    end

    // Counter parks at zero once expired, so a glitch or finished frame leaves it idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_baud_cnt <= '0;
        end else if (w_load_half) begin
            r_baud_cnt <= HALF_RELOAD;
        end else if (w_load_full) begin
            r_baud_cnt <= FULL_RELOAD;
        end else if (!w_expired) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift[r_bit_idx] <= w_rxs;
            end
        end
    end

    // Completion outranks the host read; a read on the completion cycle only suppresses overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= 8'h00;
            r_rxrdy <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_complete) begin
            r_data  <= r_shift;
            r_rxrdy <= 1'b1;
            r_ferr  <= ~w_rxs;
            r_ovf   <= (r_rxrdy | r_ovf) & ~rd;
        end else if (rd) begin
            r_rxrdy <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_par_err <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (w_par_en) begin
                r_par_err <= ^{r_shift, w_rxs};
            end
            if (w_complete) begin
                r_perr <= r_par_err;
            end else if (rd) begin
                r_perr <= 1'b0;
            end
        end
    end

    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    assign data  = r_data;
    assign rxrdy = r_rxrdy;
    assign ferr  = r_ferr;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed testbench for uart_rx_engine at BAUD_DIV=16; honours UART_RX_PARITY_EN for frame shape.
module tb_uart_rx_engine;

    localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Cycle (counted from the start-bit drive) whose following edge completes the frame.
    localparam int COMPLETE_C = 3 + BD / 2 + (NBITS - 1) * BD - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd;
    logic [7:0] data;
    logic       rxrdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_engine #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rd    (rd),
        .data  (data),
        .rxrdy (rxrdy),
        .perr  (perr),
        .ferr  (ferr),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; rd_c / rst_c pick the frame cycle for a read strobe / reset (-1 = none).
    task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit,
                              input int rd_c, input int rst_c);
        logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, par_bit, b, 1'b0};
`else
        bits = {stop_bit, b, 1'b0};
`endif
        $display("frame data=0x%02h parity=%0b stop=%0b rd_cycle=%0d rst_cycle=%0d",
                 b, par_bit, stop_bit, rd_c, rst_c);
        for (int c = 0; c < NBITS * BD; c++) begin
            if (c == rst_c) begin
                reset = 1'b0;
                rx    = 1'b1;
                rd    = 1'b0;
                step(2);
                reset = 1'b1;
                break;
            end
            rx = bits[c / BD];
            rd = (c == rd_c);
            step(1);
        end
        rx = 1'b1;
        rd = 1'b0;
    endtask

    task automatic rd_pulse();
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rd    = 1'b0;
        rx    = 1'b0;
        step(1);
        rx = 1'b1;
        @(posedge clk);
        rx = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b0000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h00) begin
            $display("FAIL reset_data: got %h expected %h", data, 8'h00);
            miscompares++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        step(4);
        send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
            $display("FAIL a5_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'hA5) begin
            $display("FAIL a5_data: got %h expected %h", data, 8'hA5);
            miscompares++;
        end
        step(1);
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(30);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
            $display("FAIL glitch_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'hA5) begin
            $display("FAIL glitch_data: got %h expected %h", data, 8'hA5);
            miscompares++;
        end
        step(1);
        rd_pulse();
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b0000) begin
            $display("FAIL rd_clear: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b0000);
            miscompares++;
        end
        step(1);
        send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
            $display("FAIL 3c_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h3C) begin
            $display("FAIL 3c_data: got %h expected %h", data, 8'h3C);
            miscompares++;
        end
        step(1);
        rd_pulse();
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0, 1'b0, -1, -1);
        step(40);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1010) begin
            $display("FAIL ferr_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1010);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h55) begin
            $display("FAIL ferr_data: got %h expected %h", data, 8'h55);
            miscompares++;
        end
        step(1);
        rd_pulse();
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b0000) begin
            $display("FAIL ferr_clear: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b0000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h55) begin
            $display("FAIL ferr_data_kept: got %h expected %h", data, 8'h55);
            miscompares++;
        end
        step(1);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b0, 1'b1, -1, -1);
        send_frame(8'h22, 1'b0, 1'b1, -1, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1001) begin
            $display("FAIL ovf_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1001);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h22) begin
            $display("FAIL ovf_data: got %h expected %h", data, 8'h22);
            miscompares++;
        end
        step(1);
        rd_pulse();
        send_frame(8'h11, 1'b0, 1'b1, -1, -1);
        send_frame(8'h22, 1'b0, 1'b1, COMPLETE_C, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
            $display("FAIL rd_prio_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h22) begin
            $display("FAIL rd_prio_data: got %h expected %h", data, 8'h22);
            miscompares++;
        end
        step(1);
        rd_pulse();
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, -1, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
            $display("FAIL par_good_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1000);
            miscompares++;
        end
        step(1);
        rd_pulse();
        send_frame(8'h07, 1'b0, 1'b1, -1, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1100) begin
            $display("FAIL par_bad_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1100);
            miscompares++;
        end
`else
        send_frame(8'h07, 1'b0, 1'b1, -1, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
            $display("FAIL nopar_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1000);
            miscompares++;
        end
`endif
        vectors++;
        if (data !== 8'h07) begin
            $display("FAIL par_data: got %h expected %h", data, 8'h07);
            miscompares++;
        end
        step(1);
        rd_pulse();
    endtask

    task automatic test_reset_midframe();
        send_frame(8'hF0, 1'b0, 1'b1, -1, 5 * BD + BD / 2);
        step(60);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b0000) begin
            $display("FAIL midrst_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b0000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h00) begin
            $display("FAIL midrst_data: got %h expected %h", data, 8'h00);
            miscompares++;
        end
        step(1);
        send_frame(8'h81, 1'b0, 1'b1, -1, -1);
        @(negedge clk);
        vectors++;
        if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
            $display("FAIL 81_flags: got %b expected %b", {rxrdy, perr, ferr, ovf}, 4'b1000);
            miscompares++;
        end
        vectors++;
        if (data !== 8'h81) begin
            $display("FAIL 81_data: got %h expected %h", data, 8'h81);
            miscompares++;
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
